// File: rtl/logic_cfg_sequencer.sv
// Serial loader for the per-fragment input-inverter bits (XAS1/XAS2/XBS1/XBS2).
// Optional chain readback on SDI is compiled in with LOGIC_CFG_READBACK_EN.
module logic_cfg_sequencer #(
    parameter int NUM_FRAGS = 8,
    parameter int CLK_DIV   = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [3:0] CFG_DATA,
    input  logic       CFG_VALID,
    output logic       CFG_READY,
    output logic       BUSY,
    output logic       SCLK,
    output logic       SDO,
    output logic       SLATCH,
`ifdef LOGIC_CFG_READBACK_EN
    output logic       DONE,
    input  logic       SDI,
    output logic [3:0] RB_DATA,
    output logic       RB_VALID
`else
    output logic       DONE
`endif
);

    localparam int FW = (NUM_FRAGS > 1) ? $clog2(NUM_FRAGS) : 1;
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [FW-1:0] FRAG_LAST = FW'(NUM_FRAGS - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [FW-1:0] frag_q;
    logic [DW-1:0] div_q;
    logic [1:0]    bit_q;
    logic          phase_q;
    logic [3:0]    sreg_q;
    logic          ready_q, busy_q, sclk_q, sdo_q, slatch_q, done_q;
`ifdef LOGIC_CFG_READBACK_EN
    logic [3:0]    rb_data_q;
    logic          rb_valid_q;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            frag_q   <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            sreg_q   <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            sclk_q   <= 1'b0;
            sdo_q    <= 1'b0;
            slatch_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef LOGIC_CFG_READBACK_EN
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
`endif
        end else begin
`ifdef LOGIC_CFG_READBACK_EN
            rb_valid_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        state_q <= S_LOAD;
                        frag_q  <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // ready_q is high for the whole LOAD visit, so VALID alone completes the handshake
                    if (CFG_VALID) begin
                        sreg_q  <= CFG_DATA;
                        sdo_q   <= CFG_DATA[3];
                        bit_q   <= '0;
                        div_q   <= '0;
                        phase_q <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + 1'b1;
                    end else begin
                        div_q <= '0;
                        if (!phase_q) begin
                            phase_q <= 1'b1;
                            sclk_q  <= 1'b1;
`ifdef LOGIC_CFG_READBACK_EN
                            // sample the chain tail on the same edge the chain sees SCLK rise
                            rb_data_q  <= {rb_data_q[2:0], SDI};
                            rb_valid_q <= (bit_q == 2'd3);
`endif
                        end else begin
                            phase_q <= 1'b0;
                            sclk_q  <= 1'b0;
                            if (bit_q != 2'd3) begin
                                bit_q  <= bit_q + 2'd1;
                                sreg_q <= {sreg_q[2:0], 1'b0};
                                sdo_q  <= sreg_q[2];
                            end else if (frag_q == FRAG_LAST) begin
                                slatch_q <= 1'b1;
                                state_q  <= S_LATCH;
                            end else begin
                                frag_q  <= frag_q + 1'b1;
                                ready_q <= 1'b1;
                                state_q <= S_LOAD;
                            end
                        end
                    end
                end
                S_LATCH: begin
                    slatch_q <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    sdo_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign CFG_READY = ready_q;
    assign BUSY      = busy_q;
    assign SCLK      = sclk_q;
    assign SDO       = sdo_q;
    assign SLATCH    = slatch_q;
    assign DONE      = done_q;
`ifdef LOGIC_CFG_READBACK_EN
    assign RB_DATA   = rb_data_q;
    assign RB_VALID  = rb_valid_q;
`endif

endmodule

// File: tb/tb_logic_cfg_sequencer.sv
// Scoreboard bench: instance A (NUM_FRAGS=2, CLK_DIV=1) and instance B (NUM_FRAGS=1, CLK_DIV=3).
module tb_logic_cfg_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_start, a_valid, a_ready, a_busy, a_sclk, a_sdo, a_slatch, a_done;
    logic [3:0] a_data;
    logic       b_start, b_valid, b_ready, b_busy, b_sclk, b_sdo, b_slatch, b_done;
    logic [3:0] b_data;
`ifdef LOGIC_CFG_READBACK_EN
    logic       a_sdi, a_rb_valid, b_sdi, b_rb_valid;
    logic [3:0] a_rb_data, b_rb_data;
    logic [7:0] pat = 8'b1101_0010;
    logic [3:0] qrb[$];
    int         rb_cnt = 0;
`endif

    logic_cfg_sequencer #(.NUM_FRAGS(2), .CLK_DIV(1)) u_dut_a (
        .CLK(clk), .RST(rst), .START(a_start), .CFG_DATA(a_data), .CFG_VALID(a_valid),
        .CFG_READY(a_ready), .BUSY(a_busy), .SCLK(a_sclk), .SDO(a_sdo), .SLATCH(a_slatch),
`ifdef LOGIC_CFG_READBACK_EN
        .SDI(a_sdi), .RB_DATA(a_rb_data), .RB_VALID(a_rb_valid),
`endif
        .DONE(a_done)
    );

    logic_cfg_sequencer #(.NUM_FRAGS(1), .CLK_DIV(3)) u_dut_b (
        .CLK(clk), .RST(rst), .START(b_start), .CFG_DATA(b_data), .CFG_VALID(b_valid),
        .CFG_READY(b_ready), .BUSY(b_busy), .SCLK(b_sclk), .SDO(b_sdo), .SLATCH(b_slatch),
`ifdef LOGIC_CFG_READBACK_EN
        .SDI(b_sdi), .RB_DATA(b_rb_data), .RB_VALID(b_rb_valid),
`endif
        .DONE(b_done)
    );

    int   ncmp = 0, nerr = 0;
    int   cyc = 0, base_a = 0, base_b = 0;
    int   rises_a = 0, slatch_cnt = 0, done_cnt = 0, busy_cnt = 0, slatch_idx = -1, done_idx = -1;
    int   rises_b = 0, b_hi = 0, b_lo = 0, b_slatch_idx = -1, b_done_idx = -1;
    logic sclk_pa = 1'b0, sclk_pb = 1'b0;
    logic qa[$];
    logic qb[$];
    int   s0, d0, bz0, r0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle and run both output monitors at the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (a_sclk && !sclk_pa) begin
            rises_a++;
            if (qa.size() > 0) chk("a_sdo_bit", a_sdo, qa.pop_front());
            else chk("a_sclk_unexpected_rise", a_sclk, 1'b0);
`ifdef LOGIC_CFG_READBACK_EN
            a_sdi = pat[7 - (rises_a % 8)];
`endif
        end
        sclk_pa = a_sclk;
        if (a_slatch) begin slatch_cnt++; slatch_idx = cyc - base_a; end
        if (a_done)   begin done_cnt++;   done_idx   = cyc - base_a; end
        if (a_busy) busy_cnt++;
`ifdef LOGIC_CFG_READBACK_EN
        if (a_rb_valid) begin
            rb_cnt++;
            if (qrb.size() > 0) chk("a_rb_data", {28'd0, a_rb_data}, {28'd0, qrb.pop_front()});
        end
`endif
        if (b_sclk && !sclk_pb) begin
            rises_b++;
            chk("b_low_len", b_lo, 3);
            b_lo = 0;
            if (qb.size() > 0) chk("b_sdo_bit", b_sdo, qb.pop_front());
            else chk("b_sclk_unexpected_rise", b_sclk, 1'b0);
        end
        if (!b_sclk && sclk_pb) begin
            chk("b_high_len", b_hi, 3);
            b_hi = 0;
        end
        if (b_sclk) b_hi++;
        else if (b_busy && !b_ready && !b_slatch && !b_done) b_lo++;
        sclk_pb = b_sclk;
        if (b_slatch) b_slatch_idx = cyc - base_b;
        if (b_done)   b_done_idx   = cyc - base_b;
    endtask

    task automatic start_a();
        a_start = 1'b1;
        base_a  = cyc;
        tick();
        a_start = 1'b0;
    endtask

    // Offer one nibble; optionally hold VALID low for `stall` LOAD cycles first.
    task automatic feed(input logic [3:0] d, input int stall, input logic hold);
        int n = 0;
        a_data  = d;
        a_valid = (stall == 0);
        while (!a_ready && n < 200) begin tick(); n++; end
        if (!a_ready) begin
            chk("feed_ready_timeout", a_ready, 1'b1);
            return;
        end
        for (int i = 0; i < stall; i++) begin
            chk("bp_ready", a_ready, 1'b1);
            chk("bp_sclk", a_sclk, 1'b0);
            chk("bp_sdo_hold", a_sdo, hold);
            tick();
        end
        a_valid = 1'b1;
        qa.push_back(d[3]); qa.push_back(d[2]); qa.push_back(d[1]); qa.push_back(d[0]);
        tick();
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!a_done && n < bound) begin tick(); n++; end
        if (!a_done) chk("a_done_timeout", a_done, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_valid = 1'b0; a_data = 4'h0;
        b_start = 1'b0; b_valid = 1'b0; b_data = 4'h0;
`ifdef LOGIC_CFG_READBACK_EN
        a_sdi = pat[7];
        b_sdi = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_ready", a_ready, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_sclk", a_sclk, 1'b0);
        chk("rst_sdo", a_sdo, 1'b0);
        chk("rst_slatch", a_slatch, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_b_busy", b_busy, 1'b0);
`ifdef LOGIC_CFG_READBACK_EN
        chk("rst_rb_data", {28'd0, a_rb_data}, 32'd0);
        chk("rst_rb_valid", a_rb_valid, 1'b0);
`endif
        rst = 1'b0;
        tick();

        // VALID while idle is not consumed
        a_valid = 1'b1; a_data = 4'hF;
        repeat (3) begin
            tick();
            chk("idle_ready", a_ready, 1'b0);
            chk("idle_busy", a_busy, 1'b0);
        end
        a_valid = 1'b0;

        // Basic load A then 3
        s0 = slatch_cnt; bz0 = busy_cnt;
`ifdef LOGIC_CFG_READBACK_EN
        qrb.push_back(4'hD); qrb.push_back(4'h2);
`endif
        start_a();
        feed(4'hA, 0, 1'b0);
        feed(4'h3, 0, 1'b0);
        a_valid = 1'b0;
        wait_done(200);
        repeat (3) tick();
        chk("basic_slatch_cycle", slatch_idx, 19);
        chk("basic_done_cycle", done_idx, 20);
        chk("basic_busy_cycles", busy_cnt - bz0, 20);
        chk("basic_slatch_count", slatch_cnt - s0, 1);
        chk("basic_bits_left", qa.size(), 0);
`ifdef LOGIC_CFG_READBACK_EN
        chk("rb_pulses", rb_cnt, 2);
`endif

        // Backpressure: 5 idle LOAD cycles before second nibble
        start_a();
        feed(4'hA, 0, 1'b0);
        feed(4'h3, 5, 1'b0);
        a_valid = 1'b0;
        wait_done(200);
        repeat (2) tick();
        chk("bp_slatch_cycle", slatch_idx, 24);
        chk("bp_done_cycle", done_idx, 25);

        // START pulse mid-shift is ignored
        s0 = slatch_cnt; d0 = done_cnt;
        start_a();
        feed(4'h5, 0, 1'b0);
        a_start = 1'b1; tick(); a_start = 1'b0;
        feed(4'hC, 0, 1'b0);
        a_valid = 1'b0;
        wait_done(200);
        repeat (6) tick();
        chk("ign_slatch_count", slatch_cnt - s0, 1);
        chk("ign_done_count", done_cnt - d0, 1);
        chk("ign_busy_after", a_busy, 1'b0);

        // Reset in the third bit of fragment 1
        s0 = slatch_cnt;
        start_a();
        feed(4'hA, 0, 1'b0);
        feed(4'h3, 0, 1'b0);
        a_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", a_ready, 1'b0);
        chk("mid_rst_busy", a_busy, 1'b0);
        chk("mid_rst_sclk", a_sclk, 1'b0);
        chk("mid_rst_sdo", a_sdo, 1'b0);
        chk("mid_rst_slatch", a_slatch, 1'b0);
        chk("mid_rst_done", a_done, 1'b0);
        qa.delete();
        repeat (30) tick();
        chk("mid_rst_no_slatch", slatch_cnt - s0, 0);
        chk("mid_rst_idle", a_busy, 1'b0);
        r0 = rises_a; s0 = slatch_cnt;
        start_a();
        feed(4'h6, 0, 1'b0);
        feed(4'h9, 0, 1'b0);
        a_valid = 1'b0;
        wait_done(200);
        repeat (2) tick();
        chk("fresh_sclk_pulses", rises_a - r0, 8);
        chk("fresh_slatch_count", slatch_cnt - s0, 1);
        chk("fresh_bits_left", qa.size(), 0);

        // Clock divide on instance B
        qb.push_back(1'b0); qb.push_back(1'b0); qb.push_back(1'b0); qb.push_back(1'b1);
        b_data = 4'h1; b_valid = 1'b1;
        b_start = 1'b1; base_b = cyc; tick(); b_start = 1'b0;
        begin
            int n = 0;
            while (!b_done && n < 300) begin tick(); n++; end
            if (!b_done) chk("b_done_timeout", b_done, 1'b1);
        end
        repeat (2) tick();
        b_valid = 1'b0;
        chk("div_slatch_cycle", b_slatch_idx, 26);
        chk("div_done_cycle", b_done_idx, 27);
        chk("div_sclk_pulses", rises_b, 4);
        chk("div_bits_left", qb.size(), 0);
        chk("div_busy_after", b_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/logic_cfg_sequencer.md
Name: logic_cfg_sequencer

Overview:
- Loads the per-fragment input-inverter configuration bits XAS1, XAS2, XBS1 and XBS2 into a serial configuration chain covering NUM_FRAGS mux fragments.
- Accepts one 4-bit configuration nibble per fragment over a valid/ready handshake and shifts it out MSB-first on SDO/SCLK.
- After the last fragment, pulses SLATCH so all fragments update together.
- Sits between the fabric configuration controller and the logic-cell inverter chain.

Parameters:
- NUM_FRAGS, 8, number of fragments in the chain (>=1); fragment counter width is clog2(NUM_FRAGS), minimum 1.
- CLK_DIV, 1, CLK cycles per SCLK half-period (>=1); half-period counter width is clog2(CLK_DIV+1).

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  one-cycle request to begin a load sequence; sampled only in IDLE.
- CFG_DATA  input  4  fragment nibble: [0]=XAS1, [1]=XAS2, [2]=XBS1, [3]=XBS2.
- CFG_VALID  input  1  CFG_DATA is valid.
- CFG_READY  output  1  sequencer accepts CFG_DATA this cycle.
- BUSY  output  1  high from the cycle after START until the cycle after DONE.
- SCLK  output  1  chain shift clock; the chain samples SDO on the rising edge.
- SDO  output  1  chain serial data.
- SLATCH  output  1  one-cycle chain update strobe.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered. In reset and in IDLE, CFG_READY, BUSY, SCLK, SDO, SLATCH and DONE are all 0.
- States:
  - IDLE: START=1 -> LOAD; fragment counter is cleared to 0.
  - LOAD: CFG_READY=1. When CFG_VALID&CFG_READY, capture CFG_DATA into the 4-bit shift register, clear the bit counter, then -> SHIFT. There is no timeout; the sequencer waits indefinitely for CFG_VALID.
  - SHIFT: four bits per fragment, order CFG_DATA[3],[2],[1],[0].
    - Each bit first spends CLK_DIV cycles with SCLK=0 and SDO=bit, then CLK_DIV cycles with SCLK=1 and SDO held.
    - SCLK returns to 0 in the first cycle of the next bit, or on leaving SHIFT.
  - After bit [0]'s high phase:
    - if fragment counter == NUM_FRAGS-1 -> LATCH;
    - otherwise increment the fragment counter and -> LOAD.
  - LATCH: SLATCH=1 for exactly one cycle; SCLK=0. Then -> DONE.
  - DONE: DONE=1 for exactly one cycle, then -> IDLE.
- CFG_READY is high only in LOAD. It is registered, so its deassertion follows the accepted transfer by one cycle; at most one nibble is accepted per LOAD visit.
- BUSY=1 in LOAD, SHIFT, LATCH and DONE.
- START while BUSY is ignored; it is not queued.
- CFG_VALID outside LOAD is ignored; data is not consumed.
- Fragment 0's nibble is shifted first and so ends farthest down the chain.
- Latency with CFG_VALID held high, START sampled at edge 0:
  - LOAD occupies cycle 1.
  - SLATCH is in cycle NUM_FRAGS*(1+8*CLK_DIV)+1.
  - DONE follows one cycle later.
- NUM_FRAGS=1: LOAD is entered once, and SHIFT goes directly to LATCH.
- RST mid-sequence: next cycle is IDLE with all outputs 0 and counters cleared. SLATCH is never issued for a partial load.

Optional Feature:
- Macro: LOGIC_CFG_READBACK_EN.
- Defined:
  - Adds ports SDI (input, 1, chain tail), RB_DATA (output, 4) and RB_VALID (output, 1).
  - SDI is sampled in the CLK cycle where SCLK goes 0->1 and shifted into RB_DATA LSB-first positions, so the first sampled bit lands in RB_DATA[3].
  - After the fourth sample of each fragment, RB_VALID pulses for one cycle with the previous chain contents; NUM_FRAGS pulses occur per sequence.
  - RB_DATA and RB_VALID reset to 0.
- Undefined: none of these ports or capture logic exist. All other behaviour is identical.

Test Plan:
- Basic load, NUM_FRAGS=2, CLK_DIV=1, CFG_VALID high, data 4'hA then 4'h3 -> SDO bits at SCLK rises are 1,0,1,0,0,0,1,1; SLATCH in cycle 19; DONE in cycle 20; BUSY cycles 1-20.
- Backpressure: CFG_VALID low for 5 cycles in second LOAD -> CFG_READY stays 1, SCLK stays 0, SDO stays unchanged; DONE is delayed by exactly 5 cycles.
- Clock divide, CLK_DIV=3, NUM_FRAGS=1, data 4'h1 -> SCLK low 3 / high 3 per bit, 4 pulses; SLATCH in cycle 26, DONE in cycle 27.
- START pulse during SHIFT and CFG_VALID pulse in IDLE -> no effect; exactly one SLATCH per sequence.
- RST asserted in the third SHIFT bit of fragment 1 -> next cycle all outputs 0; no SLATCH. A fresh START completes normally with 8 SCLK pulses for NUM_FRAGS=2.
- LOGIC_CFG_READBACK_EN defined, SDI driving pattern 1,1,0,1,0,0,1,0 -> RB_VALID pulses twice, with RB_DATA=4'hD then 4'h2.
